led_color_mapper: RTL
=====================

# led_color_mapper

Consumes the completed pixel→LED calibration table during normal (non-calibration) operation. It streams a frame's pixels, looks up each pixel's LED ID in the table, and captures one color per LED into a double-buffered color store. It then serves the LED strand driver's per-LED requests with those colors. It sits between the frame source, the calibration table's external read port, and the LED driver, and replaces the ID pattern generator's output whenever calibration is off.

## Interface
Parameters:
- NUM_LEDS, 50, number of LEDs on the strand.
- LED_ADDRESS_WIDTH, 10, LED IDs and LED requests are LED_ADDRESS_WIDTH+1 bits wide.
- NUM_FRAME_BUFFER_PIXELS, 360*180, pixel count. CAL_TABLE_COUNTER_WIDTH = $clog2(NUM_FRAME_BUFFER_PIXELS).

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- pixel_in_valid  in  1  pixel beat qualifier.
- pixel_in_address  in  CAL_TABLE_COUNTER_WIDTH  pixel index.
- pixel_in_red / pixel_in_green / pixel_in_blue  in  8 each  pixel color.
- frame_done  in  1  one-cycle pulse marking the last beat of a frame; may coincide with the final pixel_in_valid.
- cal_table_read_request_address  out  CAL_TABLE_COUNTER_WIDTH  table lookup address.
- cal_table_read_data  in  LED_ADDRESS_WIDTH+1  table entry, returned 2 cycles after the address.
- next_led_request  in  LED_ADDRESS_WIDTH+1  LED index requested by the strand driver.
- red_out / green_out / blue_out  out  8 each  color for the requested LED.
- color_valid  out  1  one-cycle pulse qualifying the color outputs.
- frame_swapped  out  1  one-cycle pulse when a new frame becomes displayable.

## Operation
- Table entry 0 means no LED. An entry k with 1 ≤ k ≤ NUM_LEDS maps to LED index k−1. Entries above NUM_LEDS are ignored.
- cal_table_read_request_address is a combinational copy of pixel_in_address.
- Capture pipeline: pixel_in_valid, the color, and frame_done are delayed through 2 register stages so they align with cal_table_read_data.
- At stage 2, for a valid pixel with an in-range ID, the color is written to the shadow bank at LED k−1 and the shadow hit bit is set. This happens only if the hit bit is clear (first hit wins; see Configuration).
- Swap: when stage-2 frame_done is high, the shadow and display banks exchange roles and the new shadow hit vector is cleared. frame_swapped pulses the same cycle. A pixel in the same stage-2 slot is written to the old shadow bank before the swap takes effect.
- LED side:
  - next_led_request is registered. Any change of value versus the registered copy, plus the first cycle after reset, triggers a lookup in the display bank.
  - If the index is below NUM_LEDS and its display hit bit is set, the stored color is output. Otherwise the output is 0,0,0.
  - color_valid pulses with the result.
- Lookups read the display bank only, so capture and serving never contend.

## Timing
- Reset values: all color outputs 0, color_valid 0, frame_swapped 0, pipeline valids 0, both hit vectors 0, display bank = bank 0.
- Reset mid-frame drops all in-flight pixels and any pending swap.
- Capture latency: pixel accepted at cycle N is written at N+2. frame_done at N swaps at N+2.
- LED latency: a request change sampled at cycle N produces color_valid high at N+2, for exactly 1 cycle. Outputs hold their value until the next result.
- A request change at N+1 during an outstanding lookup is pipelined, giving a second result at N+3.
- A swap coinciding with a lookup: a lookup issued before the swap cycle reads the old display bank. A lookup issued in or after the swap cycle reads the new one.
- Back-to-back frame_done pulses each swap. A frame with zero hits makes every LED black.

## Configuration
- CAL_MAPPER_LAST_HIT_EN:
  - Defined: the hit bit does not gate writes. Every in-range pixel overwrites, so the last pixel in scan order wins.
  - Undefined (default): the first pixel in scan order wins.
- Hit bits are still maintained in both modes for black-out of unhit LEDs.

## Structure
- Shared package cal_pkg holds:
  - a packed rgb_t struct (red, green, blue, 8 bits each);
  - the CAL_PIPE_DEPTH = 2 constant;
  - the LED_ID_NONE = 0 constant.
- Sub-module led_color_bank: 2×NUM_LEDS×24 storage plus 2×NUM_LEDS hit vectors. It has one write port (shadow), one 2-cycle read port (display), and bank-select and clear-on-swap logic. The top module holds the capture pipeline, swap control and request-change detection.

## Test plan
- Reset, then next_led_request = 0 → color_valid at cycle 2, color 0,0,0; frame_swapped never pulses.
- Table maps pixels 10 and 20 to ID 3. Stream pixel 10 = (255,0,0) and pixel 20 = (0,255,0), then frame_done, then request LED 2:
  - default build → (255,0,0) 2 cycles after the request;
  - with CAL_MAPPER_LAST_HIT_EN → (0,255,0).
- frame_done on the same beat as the last pixel (ID 1, color 0x112233) → after the swap, LED 0 returns 0x112233.
- Entries 0, NUM_LEDS+1 and 1023 written with color 0xFFFFFF, then a swap → every LED reads black. Separately, next_led_request = NUM_LEDS → black, with color_valid.
- Request changes on cycles N and N+1 → color_valid on N+2 and N+3 with the respective colors. A swap at N+1 → the second result comes from the new bank.
- rst asserted mid-frame after pixels have streamed with no frame_done → after reset, all LEDs read black and frame_swapped stays 0.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared types and constants for the calibration-table consumers.
package cal_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  localparam int CAL_PIPE_DEPTH = 2;
  localparam int LED_ID_NONE    = 0;

endpackage

// File: rtl/led_color_bank.sv
// Double-buffered per-LED color store: shadow write port, 2-cycle display read port, swap/clear.
// CAL_MAPPER_LAST_HIT_EN lets later pixels overwrite an LED already hit this frame.
module led_color_bank
  import cal_pkg::*;
#(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  localparam int IDX_W            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  rgb_t                       wr_rgb,
  input  logic                       swap,
  input  logic                       rd_req,
  input  logic [LED_ADDRESS_WIDTH:0] rd_led,
  output rgb_t                       rd_rgb,
  output logic                       rd_vld
);

  logic                      disp_sel;
  logic                      shadow_sel;
  logic [1:0][NUM_LEDS-1:0]  hit;
  rgb_t                      mem [2][NUM_LEDS];
  logic                      wr_gate;

  assign shadow_sel = ~disp_sel;

`ifdef CAL_MAPPER_LAST_HIT_EN
  assign wr_gate = wr_en;
`else
  assign wr_gate = wr_en && !hit[shadow_sel][wr_idx];
`endif

  // Hit bits are always set on a hit so unhit LEDs black out in either mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sel <= 1'b0;
      hit      <= '0;
    end else begin
      if (wr_en) hit[shadow_sel][wr_idx] <= 1'b1;
      if (swap) begin
        hit[disp_sel] <= '0;
        disp_sel      <= shadow_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_gate) mem[shadow_sel][wr_idx] <= wr_rgb;
  end

  logic                 rd_in_range;
  logic                 rd_vld_p1;
  logic                 rd_sel_p1;
  logic                 rd_ok_p1;
  logic [IDX_W-1:0]     rd_idx_p1;
  logic                 rd_hit_p1;

  assign rd_in_range = rd_led < (LED_ADDRESS_WIDTH+1)'(NUM_LEDS);

  // Stage p1: latch the bank choice; a lookup issued in the swap cycle targets the new display bank.
  always_ff @(posedge clk) begin
    if (rst) rd_vld_p1 <= 1'b0;
    else     rd_vld_p1 <= rd_req;
  end

  always_ff @(posedge clk) begin
    rd_sel_p1 <= swap ? shadow_sel : disp_sel;
    rd_ok_p1  <= rd_in_range;
    rd_idx_p1 <= rd_in_range ? IDX_W'(rd_led) : '0;
  end

  // Stage p2: read storage after any same-edge shadow write has landed.
  assign rd_hit_p1 = rd_ok_p1 && hit[rd_sel_p1][rd_idx_p1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_rgb <= '0;
    end else begin
      rd_vld <= rd_vld_p1;
      if (rd_vld_p1) rd_rgb <= rd_hit_p1 ? mem[rd_sel_p1][rd_idx_p1] : '0;
    end
  end

endmodule

// File: rtl/led_color_mapper.sv
// Maps streamed pixels through the calibration table into per-LED colors and serves LED requests.
// Optional CAL_MAPPER_LAST_HIT_EN (in led_color_bank) selects last-hit-wins capture.
module led_color_mapper
  import cal_pkg::*;
#(
  parameter int NUM_LEDS                 = 50,
  parameter int LED_ADDRESS_WIDTH        = 10,
  parameter int NUM_FRAME_BUFFER_PIXELS  = 360*180,
  localparam int CAL_TABLE_COUNTER_WIDTH = $clog2(NUM_FRAME_BUFFER_PIXELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pixel_in_valid,
  input  logic [CAL_TABLE_COUNTER_WIDTH-1:0] pixel_in_address,
  input  logic [7:0]                         pixel_in_red,
  input  logic [7:0]                         pixel_in_green,
  input  logic [7:0]                         pixel_in_blue,
  input  logic                               frame_done,
  output logic [CAL_TABLE_COUNTER_WIDTH-1:0] cal_table_read_request_address,
  input  logic [LED_ADDRESS_WIDTH:0]         cal_table_read_data,
  input  logic [LED_ADDRESS_WIDTH:0]         next_led_request,
  output logic [7:0]                         red_out,
  output logic [7:0]                         green_out,
  output logic [7:0]                         blue_out,
  output logic                               color_valid,
  output logic                               frame_swapped
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [LED_ADDRESS_WIDTH:0] ID_NONE = (LED_ADDRESS_WIDTH+1)'(LED_ID_NONE);
  localparam logic [LED_ADDRESS_WIDTH:0] ID_MAX  = (LED_ADDRESS_WIDTH+1)'(NUM_LEDS);

  assign cal_table_read_request_address = pixel_in_address;

  logic vld_p1, vld_p2;
  logic fd_p1, fd_p2;
  rgb_t rgb_p0, rgb_p1, rgb_p2;

  assign rgb_p0 = '{red: pixel_in_red, green: pixel_in_green, blue: pixel_in_blue};

  // Stages p1/p2: delay the pixel beat to meet the table's 2-cycle read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      fd_p1  <= 1'b0;
      fd_p2  <= 1'b0;
    end else begin
      vld_p1 <= pixel_in_valid;
      vld_p2 <= vld_p1;
      fd_p1  <= frame_done;
      fd_p2  <= fd_p1;
    end
  end

  always_ff @(posedge clk) begin
    rgb_p1 <= rgb_p0;
    rgb_p2 <= rgb_p1;
  end

  logic             wr_en_p2;
  logic [IDX_W-1:0] wr_idx_p2;

  assign wr_en_p2  = vld_p2 && (cal_table_read_data != ID_NONE) && (cal_table_read_data <= ID_MAX);
  assign wr_idx_p2 = IDX_W'(cal_table_read_data - (LED_ADDRESS_WIDTH+1)'(1));

  assign frame_swapped = fd_p2;

  logic [LED_ADDRESS_WIDTH:0] req_q;
  logic                       lookup_pend;
  logic                       lookup_p0;

  // Stage p0: a change of request, or the first cycle out of reset, starts a lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      lookup_pend <= 1'b1;
    end else begin
      req_q       <= next_led_request;
      lookup_pend <= 1'b0;
    end
  end

  assign lookup_p0 = lookup_pend || (next_led_request != req_q);

  rgb_t color;

  led_color_bank #(
    .NUM_LEDS          (NUM_LEDS),
    .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en_p2),
    .wr_idx (wr_idx_p2),
    .wr_rgb (rgb_p2),
    .swap   (fd_p2),
    .rd_req (lookup_p0),
    .rd_led (next_led_request),
    .rd_rgb (color),
    .rd_vld (color_valid)
  );

  assign red_out   = color.red;
  assign green_out = color.green;
  assign blue_out  = color.blue;

endmodule
